// File: rtl/multi_cycle_cu_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode constants, ALU operation codes and datapath mux selects.
package multi_cycle_cu_pkg;

    // State encoding is also what state_dbg reports.
    typedef enum logic [3:0] {
        RST_S    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        I_EXEC   = 4'd9,
        I_WB     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_t;

    // Instruction opcodes, instruction bits [31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes (3 significant bits, zero-extended on the port).
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation for an I-type arithmetic/logic instruction.
    function automatic logic [2:0] iTypeAluOp(input logic [5:0] op);
        case (op)
            OP_SLTI: iTypeAluOp = ALU_SLT;
            OP_ANDI: iTypeAluOp = ALU_AND;
            OP_ORI:  iTypeAluOp = ALU_OR;
            default: iTypeAluOp = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mcu_next_state.sv
// Combinational next-state decode for the multicycle control unit.
module mcu_next_state
    import multi_cycle_cu_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        memDone,
    output state_t      nextState
);

    // Memory states advance only when the access completes; TRAP is absorbing.
    always_comb begin
        nextState = RST_S;
        case (state)
            RST_S:    nextState = FETCH;
            FETCH:    nextState = memDone ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:                         nextState = R_EXEC;
                    OP_LW, OP_SW:                     nextState = MEM_ADDR;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nextState = I_EXEC;
                    OP_BEQ:                           nextState = BRANCH;
                    OP_J:                             nextState = JUMP;
                    default:                          nextState = TRAP;
                endcase
            end
            MEM_ADDR: nextState = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   nextState = memDone ? MEM_WB : MEM_RD;
            MEM_WB:   nextState = FETCH;
            MEM_WR:   nextState = memDone ? FETCH : MEM_WR;
            R_EXEC:   nextState = R_WB;
            R_WB:     nextState = FETCH;
            I_EXEC:   nextState = I_WB;
            I_WB:     nextState = FETCH;
            BRANCH:   nextState = FETCH;
            JUMP:     nextState = FETCH;
            TRAP:     nextState = TRAP;
            default:  nextState = RST_S;
        endcase
    end

endmodule

// File: rtl/multi_cycle_cu.sv
// Multicycle MIPS-style control unit: Moore FSM driving the classic
// shared-memory datapath, with optional memory stall handshake.
module multi_cycle_cu
    import multi_cycle_cu_pkg::*;
#(
    parameter int ALUOP_W  = 3,   // at least 3; upper bits read as zero
    parameter int WAIT_MEM = 1,   // 1: memory states wait on mem_ready
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         pc_src,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     state;
    state_t     nextState;
    logic       memDone;
    logic       illegalQ;
    logic [2:0] aluOpCode;

    // Without the handshake every memory access is taken to finish in one cycle.
    assign memDone = (WAIT_MEM != 0) ? mem_ready : 1'b1;

    mcu_next_state uNextState (
        .state     (state),
        .opcode    (opcode),
        .memDone   (memDone),
        .nextState (nextState)
    );

    // State register; reset lands in RST_S so no write enable fires until FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_S;
        else        state <= nextState;
    end

    // Sticky trap flag, set on the edge that enters TRAP so it tracks the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 illegalQ <= 1'b0;
        else if (nextState == TRAP) illegalQ <= 1'b1;
    end

    // Moore output decode; only the FETCH write strobes look at the handshake.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_b     = SRCB_REGB;
        aluOpCode     = ALU_ADD;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = memDone;
                pc_write  = memDone;
            end
            DECODE: begin
                alu_src_b = SRCB_IMMSH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                aluOpCode = ALU_FUNCT;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluOpCode = iTypeAluOp(opcode);
            end
            I_WB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                aluOpCode     = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    // Width adaptation of the ALU code and debug state.
    assign alu_op    = ALUOP_W'(aluOpCode);
    assign state_dbg = STATE_W'(state);
    assign illegal   = illegalQ;

endmodule
